// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one memory read at a time, presents the
// returned word to the consumer, and redirects on branch, jump, flush or halt.
module fetch_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic                    imem_rd,
  input  logic [DATA_WIDTH-1:0]   imem_data,
  output logic [DATA_WIDTH-1:0]   instr,
  output logic [ADDR_WIDTH-1:0]   instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    branch_taken,
  input  logic [OFFSET_WIDTH-1:0] branch_offset,
  input  logic                    jump,
  input  logic [ADDR_WIDTH-1:0]   jump_target,
  input  logic                    halt,
  input  logic                    flush,
  input  logic [ADDR_WIDTH-1:0]   flush_target,
  output logic                    halted,
  output logic [31:0]             fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALTED
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic                    imem_rd_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [ADDR_WIDTH-1:0]   instr_pc_q;
  logic                    instr_valid_q;
  logic                    halted_q;
  logic [31:0]             fetch_count_q;
  logic [3:0]              lat_cnt_q;

  logic [ADDR_WIDTH-1:0]   seq_pc;
  logic [ADDR_WIDTH-1:0]   branch_pc;
  logic [ADDR_WIDTH-1:0]   redirect_pc_d;
  logic                    flush_ok;

  // The size cast of a signed operand sign-extends (or wraps when narrower).
  always_comb begin
    seq_pc        = instr_pc_q + ADDR_WIDTH'(1);
    branch_pc     = seq_pc + ADDR_WIDTH'($signed(branch_offset));
    redirect_pc_d = seq_pc;
    if (jump)              redirect_pc_d = jump_target;
    else if (branch_taken) redirect_pc_d = branch_pc;
  end

  assign flush_ok = flush && (state_q == S_REQ || state_q == S_WAIT || state_q == S_VALID);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order in this block.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      imem_rd_q     <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
      lat_cnt_q     <= '0;
    end else begin
      imem_rd_q <= 1'b0;
      if (flush_ok) begin
        state_q       <= S_REQ;
        pc_q          <= flush_target;
        imem_rd_q     <= 1'b1;
        instr_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q   <= S_REQ;
              pc_q      <= RESET_PC;
              imem_rd_q <= 1'b1;
            end
          end
          S_REQ: begin
            state_q   <= S_WAIT;
            lat_cnt_q <= 4'(MEM_LATENCY);
          end
          S_WAIT: begin
            // Counter reaches 1 in the cycle the response is on imem_data.
            if (lat_cnt_q == 4'd1) begin
              state_q       <= S_VALID;
              instr_q       <= imem_data;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
            end else begin
              lat_cnt_q <= lat_cnt_q - 4'd1;
            end
          end
          S_VALID: begin
            if (instr_ready) begin
              fetch_count_q <= fetch_count_q + 32'd1;
              instr_valid_q <= 1'b0;
              if (halt) begin
                state_q  <= S_HALTED;
                halted_q <= 1'b1;
              end else begin
                state_q   <= S_REQ;
                pc_q      <= redirect_pc_d;
                imem_rd_q <= 1'b1;
              end
            end
          end
          S_HALTED: state_q <= S_HALTED;
          default:  state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign imem_addr   = pc_q;
  assign imem_rd     = imem_rd_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of the word-addressed PC and instruction-memory address.
REQ-002 Parameter DATA_WIDTH, 32, instruction width.
REQ-003 Parameter OFFSET_WIDTH, 16, width of the signed branch offset.
REQ-004 Parameter RESET_PC, 0, PC loaded on reset and used for the first fetch after start.
REQ-005 Parameter MEM_LATENCY, 1, instruction-memory read latency in cycles; legal range 1..8.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high.
REQ-007 clock  input  1  rising-edge clock.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  pulse; begins fetching from RESET_PC; honoured only in IDLE.
REQ-010 imem_addr  output  ADDR_WIDTH  instruction-memory word address.
REQ-011 imem_rd  output  1  instruction-memory read strobe, one cycle per request.
REQ-012 imem_data  input  DATA_WIDTH  read data, valid exactly MEM_LATENCY cycles after the imem_rd cycle.
REQ-013 instr  output  DATA_WIDTH  fetched instruction.
REQ-014 instr_pc  output  ADDR_WIDTH  address of instr.
REQ-015 instr_valid  output  1  instr/instr_pc are valid.
REQ-016 instr_ready  input  1  consumer accepts instr this cycle.
REQ-017 branch_taken  input  1  sampled on the consume cycle; redirect to instr_pc+1+sext(branch_offset).
REQ-018 branch_offset  input  OFFSET_WIDTH  signed word offset.
REQ-019 jump  input  1  sampled on the consume cycle; redirect to jump_target.
REQ-020 jump_target  input  ADDR_WIDTH  absolute jump address.
REQ-021 halt  input  1  sampled on the consume cycle; stop fetching.
REQ-022 flush  input  1  abandon the in-flight or held instruction and refetch from flush_target.
REQ-023 flush_target  input  ADDR_WIDTH  refetch address for flush.
REQ-024 halted  output  1  high while in HALTED.
REQ-025 fetch_count  output  32  number of consumed instructions, wraps modulo 2^32.

Function
REQ-026 States SHALL be IDLE, REQ, WAIT, VALID, HALTED.
REQ-027 IDLE: outputs quiescent; start=1 -> REQ with pc=RESET_PC; otherwise stay.
REQ-028 REQ: imem_rd=1 and imem_addr=pc for exactly one cycle; next WAIT, with the latency counter loaded to MEM_LATENCY.
REQ-029 WAIT: the counter decrements each cycle; in the cycle MEM_LATENCY after the REQ cycle, imem_data is registered into instr, pc is registered into instr_pc, and the state moves to VALID.
REQ-030 With the request in cycle n, instr_valid SHALL first be high in cycle n+MEM_LATENCY+1.
REQ-031 VALID: instr_valid=1; instr and instr_pc SHALL be held stable until a cycle with instr_ready=1 (consume).
REQ-032 On consume, the next pc SHALL be selected with priority halt > jump > branch_taken > sequential (instr_pc+1); the state moves to REQ, or to HALTED on halt; fetch_count increments.
REQ-033 instr_valid SHALL drop in the cycle after consume; at most one request is outstanding.
REQ-034 PC arithmetic SHALL be modulo 2^ADDR_WIDTH; branch_offset is sign-extended to ADDR_WIDTH; sequential increment wraps from all-ones to 0.
REQ-035 Flush in REQ, WAIT or VALID SHALL take priority over consume and redirects; the next state is REQ with pc=flush_target.
REQ-036 On flush, instr_valid=0 next cycle, the pending response is never captured, and fetch_count is unchanged.
REQ-037 Flush and start SHALL be ignored in IDLE and HALTED; HALTED is left only by reset.
REQ-038 Redirect inputs SHALL be ignored in any cycle that is not a consume cycle.

Reset
REQ-039 Reset SHALL override all inputs in any state, including mid-fetch, and discard any in-flight response.
REQ-040 Reset values: state IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_rd=0, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.

Verification (MEM_LATENCY=2, RESET_PC=0 unless stated)
REQ-041 Reset, then start pulse in cycle 0 -> imem_rd=1 with addr 0 in cycle 1; instr_valid=1 in cycle 4 with instr=mem[0] and instr_pc=0.
REQ-042 instr_ready held low 5 cycles -> instr and instr_pc stable throughout; on consume, the next request is to addr 1 and fetch_count=1.
REQ-043 Consume at instr_pc=10 with branch_taken=1 and branch_offset=-3 -> next fetch addr 8; with jump=1 and jump_target=0x40 also high -> addr 0x40.
REQ-044 Flush with flush_target=0x20 during WAIT -> old data never presented; next instr_pc=0x20; fetch_count unchanged.
REQ-045 Consume with halt=1 -> halted=1, imem_rd stays 0, start ignored; reset returns the block to IDLE with all outputs at REQ-040 values.
REQ-046 ADDR_WIDTH=8, MEM_LATENCY=4, sequential consume at instr_pc=0xFF -> next fetch addr 0x00; instr_valid 5 cycles after that request.
